// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous pattern scheduler: picks the renderer pattern, switching only at
// frame boundaries with one fully blanked frame between patterns.
module vga_pattern_scheduler #(
    parameter int NUM_PATTERNS       = 4,
    parameter int PAT_W              = 2,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int DEBOUNCE_FRAMES    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             frame_start,
    input  logic [PAT_W-1:0] sel_req,
    input  logic             auto_en,
    input  logic             next_btn,
    output logic [PAT_W-1:0] pattern_sel,
    output logic             blank,
    output logic             pattern_change,
    output logic [7:0]       anim_phase
);

    // state | meaning
    // SHOW  | current pattern displayed, triggers evaluated at each frame_start
    // BLANK | one black transition frame, new pattern applied at its end
    typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

    localparam int DW = (FRAMES_PER_PATTERN > 2) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0]    DWELL_MAX = DW'(FRAMES_PER_PATTERN - 1);
    localparam logic [CW-1:0]    DEB_MAX   = CW'(DEBOUNCE_FRAMES);
    localparam logic [PAT_W-1:0] PAT_LAST  = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [PAT_W:0]   PAT_NUM   = (PAT_W + 1)'(NUM_PATTERNS);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              blank_q, blank_d;
    logic              chg_q, chg_d;
    logic [7:0]        anim_q, anim_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PAT_W-1:0]  last_q, last_d;
    logic              next_q, next_d;
    logic [PAT_W-1:0]  target_q, target_d;
    logic              btn_prev_q, btn_prev_d;

    logic              rise;
    logic              stable;
    logic              valid_req;
    logic              trig;
    logic [PAT_W-1:0]  tgt;
    logic [PAT_W-1:0]  pat_inc;

    assign pat_inc   = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
    assign valid_req = ({1'b0, sel_req} < PAT_NUM);

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        blank_d    = blank_q;
        chg_d      = 1'b0;
        anim_d     = anim_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        next_d     = next_q;
        target_d   = target_q;
        btn_prev_d = btn_prev_q;
        rise       = 1'b0;
        stable     = 1'b0;
        trig       = 1'b0;
        tgt        = pat_inc;

        if (ena) begin
            btn_prev_d = next_btn;
            rise       = next_btn & ~btn_prev_q;
            next_d     = next_q | rise;

            if (frame_start) begin
                if (sel_req == last_q) begin
                    cnt_d = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_d  = CW'(1);
                    last_d = sel_req;
                end
                // The sample taken on this frame_start already counts toward stability.
                stable = (cnt_d == DEB_MAX);

                case (state_q)
                    SHOW: begin
                        if (!auto_en) begin
                            if (stable && valid_req && (sel_req != pat_q)) begin
                                trig = 1'b1;
                                tgt  = sel_req;
                            end else if (next_q) begin
                                trig = 1'b1;
                            end
                        end else if (next_q || (dwell_q == DWELL_MAX)) begin
                            trig = 1'b1;
                        end

                        if (trig) begin
                            next_d   = rise;
                            target_d = tgt;
                            state_d  = BLANK;
                            blank_d  = 1'b1;
                        end else begin
                            dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
                            anim_d  = anim_q + 8'd1;
                        end
                    end
                    BLANK: begin
                        pat_d   = target_q;
                        blank_d = 1'b0;
                        chg_d   = 1'b1;
                        dwell_d = '0;
                        anim_d  = 8'd0;
                        state_d = SHOW;
                    end
                    default: state_d = SHOW;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SHOW;
            pat_q      <= '0;
            blank_q    <= 1'b0;
            chg_q      <= 1'b0;
            anim_q     <= 8'd0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            next_q     <= 1'b0;
            target_q   <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            blank_q    <= blank_d;
            chg_q      <= chg_d;
            anim_q     <= anim_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            next_q     <= next_d;
            target_q   <= target_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign pattern_sel    = pat_q;
    assign blank          = blank_q;
    assign pattern_change = chg_q;
    assign anim_phase     = anim_q;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench: a 4-pattern and a 3-pattern scheduler share stimulus; expectations hand-derived.
module tb_vga_pattern_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       frame_start = 1'b0;
    logic [1:0] sel_req = 2'd0;
    logic       auto_en = 1'b0;
    logic       next_btn = 1'b0;

    logic [1:0] pat_a, pat_b;
    logic       blank_a, blank_b, chg_a, chg_b;
    logic [7:0] anim_a, anim_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_pattern_scheduler #(.NUM_PATTERNS(4), .PAT_W(2), .FRAMES_PER_PATTERN(4), .DEBOUNCE_FRAMES(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .frame_start(frame_start), .sel_req(sel_req),
        .auto_en(auto_en), .next_btn(next_btn), .pattern_sel(pat_a), .blank(blank_a),
        .pattern_change(chg_a), .anim_phase(anim_a));

    vga_pattern_scheduler #(.NUM_PATTERNS(3), .PAT_W(2), .FRAMES_PER_PATTERN(4), .DEBOUNCE_FRAMES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .frame_start(frame_start), .sel_req(sel_req),
        .auto_en(auto_en), .next_btn(next_btn), .pattern_sel(pat_b), .blank(blank_b),
        .pattern_change(chg_b), .anim_phase(anim_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic btn_pulse();
        @(negedge clk);
        next_btn = 1'b1;
        repeat (2) @(negedge clk);
        next_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pat", pat_a, 0);
        check("rst_blank", blank_a, 0);
        check("rst_chg", chg_a, 0);
        check("rst_anim", anim_a, 0);
        rst_n = 1'b1;

        // manual select to 2: trigger on the third frame_start
        sel_req = 2'd2;
        frame(); check("man_f1_blank", blank_a, 0); check("man_f1_anim", anim_a, 1);
        frame(); check("man_f2_blank", blank_a, 0); check("man_f2_anim", anim_a, 2);
        frame(); check("man_f3_blank", blank_a, 1); check("man_f3_pat", pat_a, 0);
        check("man_f3_anim", anim_a, 2);
        frame(); check("man_f4_pat", pat_a, 2); check("man_f4_blank", blank_a, 0);
        check("man_f4_chg", chg_a, 1); check("man_f4_anim", anim_a, 0);
        check("man_b_pat", pat_b, 2);
        @(negedge clk); check("man_chg_pulse", chg_a, 0);

        // one-frame glitch to 3 must not switch
        sel_req = 2'd3;
        frame(); check("gl_blank", blank_a, 0);
        sel_req = 2'd2;
        frame(); frame(); frame();
        check("gl_pat", pat_a, 2); check("gl_blank2", blank_a, 0); check("gl_anim", anim_a, 4);

        // enter BLANK via next_btn, then reset mid-BLANK
        btn_pulse();
        frame(); check("nb_blank", blank_a, 1); check("nb_b_blank", blank_b, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rb_pat", pat_a, 0); check("rb_blank", blank_a, 0);
        check("rb_chg", chg_a, 0); check("rb_anim", anim_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rb_nochg", chg_a, 0);
        frame(); check("rb_f_chg", chg_a, 0); check("rb_f_blank", blank_a, 0); check("rb_f_pat", pat_a, 0);

        // select 3: valid for A, invalid for B
        sel_req = 2'd3;
        frame(); frame();
        frame(); check("s3_a_blank", blank_a, 1); check("inv_b_blank1", blank_b, 0);
        frame(); check("s3_a_pat", pat_a, 3); check("s3_a_chg", chg_a, 1);
        check("inv_b_blank2", blank_b, 0); check("inv_b_pat", pat_b, 0);

        // auto cycle from 3 wraps to 0 after four shown frames
        auto_en = 1'b1;
        frame(); check("au_anim1", anim_a, 1);
        frame(); check("au_anim2", anim_a, 2);
        frame(); check("au_anim3", anim_a, 3); check("au_blank3", blank_a, 0);
        frame(); check("au_blank4", blank_a, 1); check("au_anim4", anim_a, 3);
        frame(); check("au_wrap_pat", pat_a, 0); check("au_wrap_chg", chg_a, 1);
        check("au_wrap_anim", anim_a, 0);

        // advance to 1, then next_btn coinciding with dwell expiry
        frame(); frame(); frame(); frame();
        frame(); check("au_pat1", pat_a, 1);
        frame(); frame(); frame();
        check("si_anim", anim_a, 3);
        btn_pulse();
        frame(); check("si_blank", blank_a, 1);
        frame(); check("si_pat", pat_a, 2); check("si_chg", chg_a, 1);
        frame(); check("si_noextra", blank_a, 0); check("si_pat_hold", pat_a, 2);

        // ena gating
        auto_en = 1'b0;
        sel_req = 2'd0;
        do_reset();
        frame(); frame();
        check("en_anim_pre", anim_a, 2);
        ena = 1'b0;
        frame(); frame();
        btn_pulse();
        frame(); frame(); frame();
        check("en_pat", pat_a, 0); check("en_blank", blank_a, 0);
        check("en_anim", anim_a, 2); check("en_chg", chg_a, 0);
        ena = 1'b1;
        frame(); check("en_post_blank1", blank_a, 0); check("en_post_anim1", anim_a, 3);
        frame(); check("en_post_blank2", blank_a, 0); check("en_post_pat", pat_a, 0);

        // B: invalid stable request plus next_btn arriving during BLANK
        sel_req = 2'd3;
        do_reset();
        btn_pulse();
        frame(); check("bb_blank1", blank_b, 1); check("bb_pat0", pat_b, 0);
        btn_pulse();
        frame(); check("bb_pat1", pat_b, 1); check("bb_chg1", chg_b, 1); check("bb_blank2", blank_b, 0);
        frame(); check("bb_blank3", blank_b, 1); check("bb_pat1_hold", pat_b, 1);
        frame(); check("bb_pat2", pat_b, 2); check("bb_chg2", chg_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
